// File: rtl/cic_interp_sequencer.sv
// Rate/phase sequencer for a 4-stage CIC interpolator on a single fast clock.
// Optional saturating underrun counter is enabled by defining CIC_SEQ_UNDERRUN_CNT_EN.
module cic_interp_sequencer #(
  parameter int R_MAX     = 16,
  parameter int R_DEFAULT = 2,
  parameter int CNT_W     = 8,
  parameter int INTEG_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_r,
  input  logic             cfg_load,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             din_load,
  output logic             comb_en,
  output logic             upsample_sel,
  output logic             integ_en,
  output logic             out_valid,
  output logic [CNT_W-1:0] phase,
  output logic             busy,
  output logic             underrun
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  typedef enum logic {IDLE, FRAME} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       phase_q, phase_d;
  logic [CNT_W-1:0]       r_act_q, r_act_d;
  logic [INTEG_LAT-1:0]   ov_sr_q, ov_sr_d;
  logic                   frame_end;
  logic                   cfg_legal;

  assign frame_end = (phase_q == (r_act_q - CNT_W'(1)));
  assign cfg_legal = (cfg_r >= CNT_W'(2)) && (cfg_r <= CNT_W'(R_MAX));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    r_act_d      = r_act_q;
    in_ready     = 1'b0;
    comb_en      = 1'b0;
    upsample_sel = 1'b0;
    integ_en     = 1'b0;
    underrun     = 1'b0;
    cfg_err      = 1'b0;
    din_load     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        din_load = in_valid;
        // A load accepted alongside a sample takes effect for that same frame.
        if (cfg_load) begin
          if (cfg_legal) r_act_d = cfg_r;
          else           cfg_err = 1'b1;
        end
        if (in_valid) begin
          state_d = FRAME;
          phase_d = '0;
        end
      end
      FRAME: begin
        integ_en     = 1'b1;
        comb_en      = (phase_q == '0);
        upsample_sel = (phase_q == '0);
        if (frame_end) begin
          in_ready = 1'b1;
          din_load = in_valid;
          phase_d  = '0;
          if (!in_valid) begin
            underrun = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ov_sr_d = INTEG_LAT'({ov_sr_q, integ_en});
  end

  assign phase     = phase_q;
  assign busy      = (state_q == FRAME);
  assign out_valid = ov_sr_q[INTEG_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      r_act_q <= CNT_W'(R_DEFAULT);
      ov_sr_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      r_act_q <= r_act_d;
      ov_sr_q <= ov_sr_d;
    end
  end

`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun && (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) underrun_cnt_q <= '0;
    else     underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_cic_interp_sequencer.sv
// Scoreboard bench for cic_interp_sequencer: stimulus pushes expected control
// records and out_valid cycle numbers; a negedge monitor pops and compares.
module tb_cic_interp_sequencer;

  localparam int R_MAX     = 16;
  localparam int R_DEFAULT = 2;
  localparam int CNT_W     = 8;
  localparam int INTEG_LAT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cfg_r;
  logic             cfg_load;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic             din_load;
  logic             comb_en;
  logic             upsample_sel;
  logic             integ_en;
  logic             out_valid;
  logic [CNT_W-1:0] phase;
  logic             busy;
  logic             underrun;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  logic [15:0]      underrun_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit monitorOn = 1'b0;

  logic [15:0] ctrlQ[$];
  int          ovQ[$];

  cic_interp_sequencer #(
    .R_MAX(R_MAX), .R_DEFAULT(R_DEFAULT), .CNT_W(CNT_W), .INTEG_LAT(INTEG_LAT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_r(cfg_r), .cfg_load(cfg_load), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .din_load(din_load),
    .comb_en(comb_en), .upsample_sel(upsample_sel), .integ_en(integ_en),
    .out_valid(out_valid), .phase(phase), .busy(busy), .underrun(underrun)
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pack(input logic dl, input logic ce, input logic us,
                                       input logic ie, input logic bz, input logic ur,
                                       input logic er, input logic [7:0] ph);
    return {dl, ce, us, ie, bz, ur, er, 1'b0, ph};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic ld, input logic [CNT_W-1:0] r);
    in_valid = v;
    cfg_load = ld;
    cfg_r    = r;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected per-cycle control pattern and out_valid cycles for one frame.
  task automatic expectFrame(input int r, input bit acceptAtEnd, input int start);
    for (int p = 0; p < r; p++) begin
      bit last = (p == r - 1);
      ctrlQ.push_back(pack(last && acceptAtEnd, p == 0, p == 0, 1'b1, 1'b1,
                           last && !acceptAtEnd, 1'b0, 8'(p)));
      ovQ.push_back(start + p + INTEG_LAT);
    end
  endtask

  task automatic expectIdleAccept();
    ctrlQ.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
  endtask

  task automatic expectCfgErr();
    ctrlQ.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      if (busy || din_load || underrun || cfg_err) begin
        logic [15:0] act;
        act = pack(din_load, comb_en, upsample_sel, integ_en, busy, underrun, cfg_err, phase);
        checks++;
        if (ctrlQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL ctrl_unexpected cyc=%0d actual=%h required=none", cyc, act);
        end else begin
          logic [15:0] exp;
          exp = ctrlQ.pop_front();
          if (act !== exp) begin
            failures++;
            $display("[TB] FAIL ctrl cyc=%0d actual=%h required=%h", cyc, act, exp);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (ovQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL out_valid_unexpected actual_cyc=%0d required=none", cyc);
        end else begin
          int expCyc;
          expCyc = ovQ.pop_front();
          if (expCyc != cyc) begin
            failures++;
            $display("[TB] FAIL out_valid_cycle actual=%0d required=%0d", cyc, expCyc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int c0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    monitorOn = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset_outputs",
                pack(din_load, comb_en, upsample_sel, integ_en, busy, underrun, cfg_err, phase),
                16'd0);
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    stepCycles(2);

    $display("[TB] single sample at default ratio");
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, '0);
    expectIdleAccept();
    expectFrame(2, 1'b0, c0 + 1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(10);

    $display("[TB] continuous samples at ratio 4");
    applyStimulus(1'b0, 1'b1, 8'd4);
    stepCycles(1);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, '0);
    expectIdleAccept();
    expectFrame(4, 1'b1, c0 + 1);
    expectFrame(4, 1'b1, c0 + 5);
    expectFrame(4, 1'b0, c0 + 9);
    stepCycles(9);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(14);

    $display("[TB] config loads legal, illegal and during frame");
    applyStimulus(1'b0, 1'b1, 8'd8);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 8'd1);
    expectCfgErr();
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 8'd17);
    expectCfgErr();
    stepCycles(1);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, '0);
    expectIdleAccept();
    expectFrame(8, 1'b0, c0 + 1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(2);
    applyStimulus(1'b0, 1'b1, 8'd5);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(12);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, '0);
    expectIdleAccept();
    expectFrame(8, 1'b0, c0 + 1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(14);

    $display("[TB] load and accept in the same cycle");
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 8'd3);
    expectIdleAccept();
    expectFrame(3, 1'b0, c0 + 1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(10);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(1'b0, 1'b1, 8'd4);
    stepCycles(1);
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, '0);
    expectIdleAccept();
    for (int p = 0; p < 3; p++)
      ctrlQ.push_back(pack(1'b0, p == 0, p == 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(p)));
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, '0);
    stepCycles(2);
    rst = 1'b1;
    stepCycles(1);
    rst = 1'b0;
    checkOutput("post_reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("post_reset_outputs",
                pack(din_load, comb_en, upsample_sel, integ_en, busy, underrun, cfg_err, phase),
                16'd0);
    checkOutput("post_reset_out_valid", 16'(out_valid), 16'd0);
    stepCycles(INTEG_LAT + 2);

    $display("[TB] isolated samples after reset");
    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      applyStimulus(1'b1, 1'b0, '0);
      expectIdleAccept();
      expectFrame(2, 1'b0, c0 + 1);
      stepCycles(1);
      applyStimulus(1'b0, 1'b0, '0);
      stepCycles(9);
    end
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    checkOutput("underrun_cnt", underrun_cnt, 16'd3);
`endif

    stepCycles(5);
    checkOutput("ctrl_queue_drained", 16'(ctrlQ.size()), 16'd0);
    checkOutput("out_valid_queue_drained", 16'(ovQ.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
